// File: rtl/intdiv_pkg.sv
// Shared definitions for the integer divider stages: SD2 digit encodings,
// polarity constants, the post-stage FSM states and the SD2 digit splitter.
package intdiv_pkg;

    localparam logic [1:0] NEG1   = 2'b11;
    localparam logic [1:0] ZERO   = 2'b00;
    localparam logic [1:0] POS1_1 = 2'b01;
    localparam logic [1:0] POS1_2 = 2'b10;

    localparam logic ON       = 1'b1;
    localparam logic OFF      = 1'b0;
    localparam logic POSITIVE = 1'b1;
    localparam logic NEGATIVE = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        CONVQ,
        CONVR,
        CORRQ,
        CORRR,
        DONE
    } post_state_t;

    typedef struct packed {
        logic p;
        logic m;
    } sd2_pm_t;

    // One SD2 digit becomes a bit of the positive vector P or the negative vector M.
    function automatic sd2_pm_t sd2_split(input logic [1:0] digit);
        sd2_pm_t pm;
        pm = '0;
        case (digit)
            POS1_1, POS1_2: pm.p = 1'b1;
            NEG1:           pm.m = 1'b1;
            ZERO:           pm   = '0;
            default:        pm   = '0;
        endcase
        return pm;
    endfunction

endpackage

// File: rtl/intdiv_addsub.sv
// Combinational N-bit adder/subtractor shared by every step of the post stage.
// The result wraps modulo 2^N; there is no carry out.
module intdiv_addsub #(
    parameter int N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] y
);

    assign y = sub ? (a - b) : (a + b);

endmodule

// File: rtl/intdiv_post.sv
// Divider output stage: converts SD2 quotient/remainder to binary, applies the
// +/-1 quotient and -/+divisor remainder fix-up, and hands the result off.
module intdiv_post
    import intdiv_pkg::*;
#(
    parameter int N = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] q_sd,
    input  logic [2*N-1:0] r_sd,
    input  logic [N-1:0]   x,
    input  logic           padj,
    input  logic           seladj,
    output logic [N-1:0]   q,
    output logic [N-1:0]   r,
    output logic           out_valid,
    input  logic           out_ready
);

    post_state_t    state;
    logic [2*N-1:0] q_sd_l;
    logic [2*N-1:0] r_sd_l;
    logic [N-1:0]   x_l;
    logic           padj_l;
    logic           seladj_l;

    logic [N-1:0]   q_p;
    logic [N-1:0]   q_m;
    logic [N-1:0]   r_p;
    logic [N-1:0]   r_m;
    logic [N-1:0]   add_a;
    logic [N-1:0]   add_b;
    logic [N-1:0]   add_y;
    logic           add_sub;

    always_comb begin
        q_p = '0;
        q_m = '0;
        r_p = '0;
        r_m = '0;
        for (int i = 0; i < N; i++) begin
            sd2_pm_t qd;
            sd2_pm_t rd;
            qd     = sd2_split(q_sd_l[2*i +: 2]);
            rd     = sd2_split(r_sd_l[2*i +: 2]);
            q_p[i] = qd.p;
            q_m[i] = qd.m;
            r_p[i] = rd.p;
            r_m[i] = rd.m;
        end
    end

    // Each state borrows the single adder for its own operand pair.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_sub = 1'b0;
        case (state)
            CONVQ: begin
                add_a   = q_p;
                add_b   = q_m;
                add_sub = 1'b1;
            end
            CONVR: begin
                add_a   = r_p;
                add_b   = r_m;
                add_sub = 1'b1;
            end
            CORRQ: begin
                add_a   = q;
                add_b   = N'(1);
                add_sub = (padj_l != POSITIVE);
            end
            CORRR: begin
                add_a   = r;
                add_b   = x_l;
                add_sub = (padj_l == POSITIVE);
            end
            default: begin
                add_a   = '0;
                add_b   = '0;
                add_sub = 1'b0;
            end
        endcase
    end

    intdiv_addsub #(.N(N)) u_addsub (
        .a   (add_a),
        .b   (add_b),
        .sub (add_sub),
        .y   (add_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            q         <= '0;
            r         <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            q_sd_l    <= '0;
            r_sd_l    <= '0;
            x_l       <= '0;
            padj_l    <= NEGATIVE;
            seladj_l  <= OFF;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        q_sd_l   <= q_sd;
                        r_sd_l   <= r_sd;
                        x_l      <= x;
                        padj_l   <= padj;
                        seladj_l <= seladj;
                        in_ready <= 1'b0;
                        state    <= CONVQ;
                    end
                end
                CONVQ: begin
                    q     <= add_y;
                    state <= CONVR;
                end
                CONVR: begin
                    r <= add_y;
                    if (seladj_l == ON) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        state <= CORRQ;
                    end
                end
                CORRQ: begin
                    q     <= add_y;
                    state <= CORRR;
                end
                CORRR: begin
                    r         <= add_y;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_intdiv_post.sv
// Directed bench for intdiv_post (N=8): an arithmetic reference model plus a
// per-cycle compare process, with literal expectations for the listed cases.
module tb_intdiv_post;

    localparam int N = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [2*N-1:0] q_sd;
    logic [2*N-1:0] r_sd;
    logic [N-1:0]   x;
    logic           padj;
    logic           seladj;
    logic [N-1:0]   q;
    logic [N-1:0]   r;
    logic           out_valid;
    logic           out_ready;

    int             checks = 0;
    int             errors = 0;
    logic [N-1:0]   exp_q  = '0;
    logic [N-1:0]   exp_r  = '0;

    intdiv_post #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .q_sd      (q_sd),
        .r_sd      (r_sd),
        .x         (x),
        .padj      (padj),
        .seladj    (seladj),
        .q         (q),
        .r         (r),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // Value of an SD2 vector as a plain signed sum of weighted digits.
    function automatic int sd2_value(input logic [2*N-1:0] sd);
        int v;
        v = 0;
        for (int i = 0; i < N; i++) begin
            if (sd[2*i +: 2] == 2'b11)      v -= (1 << i);
            else if (sd[2*i +: 2] != 2'b00) v += (1 << i);
        end
        return v;
    endfunction

    task automatic modelResult(input logic [2*N-1:0] qs, input logic [2*N-1:0] rs,
                               input logic [N-1:0] xv, input logic pa, input logic sa,
                               output logic [N-1:0] mq, output logic [N-1:0] mr);
        int qv;
        int rv;
        qv = sd2_value(qs);
        rv = sd2_value(rs);
        if (!sa) begin
            if (pa) begin
                qv = qv + 1;
                rv = rv - int'(xv);
            end else begin
                qv = qv - 1;
                rv = rv + int'(xv);
            end
        end
        mq = qv[N-1:0];
        mr = rv[N-1:0];
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Whenever a result is presented it must match the model and block new input.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            checkOutput("cmp_q", 32'(q), 32'(exp_q));
            checkOutput("cmp_r", 32'(r), 32'(exp_r));
            checkOutput("cmp_in_ready_busy", 32'(in_ready), 32'd0);
        end
    end

    // Drive a bundle, hold it until accepted, then scramble the inputs.
    task automatic applyStimulus(input logic [2*N-1:0] qs, input logic [2*N-1:0] rs,
                                 input logic [N-1:0] xv, input logic pa, input logic sa);
        int waited;
        q_sd     = qs;
        r_sd     = rs;
        x        = xv;
        padj     = pa;
        seladj   = sa;
        in_valid = 1'b1;
        waited   = 0;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) checkOutput("accept_timeout", 32'(in_ready), 32'd1);
        modelResult(qs, rs, xv, pa, sa, exp_q, exp_r);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        q_sd     = ~qs;
        r_sd     = ~rs;
        x        = ~xv;
        padj     = ~pa;
        seladj   = ~sa;
    endtask

    task automatic waitResult(input string name, input int lat,
                              input logic [N-1:0] lq, input logic [N-1:0] lr);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!out_valid && k < 20);
        checkOutput({name, "_latency"}, 32'(k), 32'(lat));
        checkOutput({name, "_q"}, 32'(q), 32'(lq));
        checkOutput({name, "_r"}, 32'(r), 32'(lr));
    endtask

    task automatic releaseResult(input string name);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        checkOutput({name, "_idle_in_ready"}, 32'(in_ready), 32'd1);
        checkOutput({name, "_idle_out_valid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        q_sd      = '0;
        r_sd      = '0;
        x         = '0;
        padj      = 1'b0;
        seladj    = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_q", 32'(q), 32'd0);
        checkOutput("reset_r", 32'(r), 32'd0);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(16'h0043, 16'h0008, 8'h05, 1'b0, 1'b1);
        waitResult("t1", 3, 8'h07, 8'h02);
        releaseResult("t1");

        applyStimulus(16'h0043, 16'h0008, 8'h05, 1'b0, 1'b0);
        waitResult("t2", 5, 8'h06, 8'h07);
        releaseResult("t2");

        applyStimulus(16'h0043, 16'h0008, 8'h05, 1'b1, 1'b0);
        waitResult("t3", 5, 8'h08, 8'hFD);
        releaseResult("t3");

        applyStimulus(16'h000D, 16'h0000, 8'h01, 1'b1, 1'b0);
        waitResult("t4", 5, 8'h00, 8'hFF);
        releaseResult("t4");

        // All -1 quotient (-255 -> 0x01) and all +1 remainder (0xFF), padj=0 with x=0x10.
        applyStimulus(16'hFFFF, 16'hAAAA, 8'h10, 1'b0, 1'b0);
        waitResult("t_mixed", 5, 8'h00, 8'h0F);
        releaseResult("t_mixed");

        // Backpressure: new bundle waits while the result is held.
        applyStimulus(16'h0043, 16'h0008, 8'h05, 1'b0, 1'b1);
        waitResult("t5a", 3, 8'h07, 8'h02);
        q_sd     = 16'h0055;
        r_sd     = 16'h00C0;
        x        = 8'h03;
        padj     = 1'b1;
        seladj   = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("t5_hold_out_valid", 32'(out_valid), 32'd1);
            checkOutput("t5_hold_q", 32'(q), 32'h07);
            checkOutput("t5_hold_r", 32'(r), 32'h02);
        end
        releaseResult("t5");
        // 0x55 -> 0x0F, +1 = 0x10; 0xC0 -> -8 = 0xF8, -3 = 0xF5.
        applyStimulus(16'h0055, 16'h00C0, 8'h03, 1'b1, 1'b0);
        waitResult("t5b", 5, 8'h10, 8'hF5);
        releaseResult("t5b");

        // Reset in CORRQ discards the partial result.
        applyStimulus(16'h0043, 16'h0008, 8'h05, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("t6_q", 32'(q), 32'd0);
        checkOutput("t6_r", 32'(r), 32'd0);
        checkOutput("t6_out_valid", 32'(out_valid), 32'd0);
        checkOutput("t6_in_ready", 32'(in_ready), 32'd1);
        applyStimulus(16'h0043, 16'h0008, 8'h05, 1'b1, 1'b0);
        waitResult("t6b", 5, 8'h08, 8'hFD);
        releaseResult("t6b");

        // out_ready held high throughout conversion has no early effect.
        out_ready = 1'b1;
        applyStimulus(16'h0043, 16'h0008, 8'h05, 1'b0, 1'b0);
        waitResult("t7", 5, 8'h06, 8'h07);
        @(negedge clk);
        checkOutput("t7_idle_out_valid", 32'(out_valid), 32'd0);
        checkOutput("t7_idle_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/intdiv_post.md
# intdiv_post

Final stage of the integer divider, directly downstream of the sign/adjust decision logic. It accepts the redundant SD2 quotient and remainder, plus the `padj`/`seladj` correction decision and the divisor. It converts both redundant values to two's complement, applies the ±1 quotient / ∓divisor remainder correction, and presents the binary result through a valid/ready handshake. One shared N-bit adder/subtractor is time-multiplexed across a small FSM.

## Interface
- `N`, default 16: operand width. The quotient and remainder each have N SD2 digits and N binary bits.
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: input bundle valid.
- `in_ready` out 1: block can accept a bundle. High only in IDLE.
- `q_sd` in 2N: quotient, SD2 digits. Digit i is at [2i+1:2i].
- `r_sd` in 2N: remainder, SD2 digits, same layout.
- `x` in N: divisor, two's complement.
- `padj` in 1: correction direction.
- `seladj` in 1: 1 = no correction, 0 = apply correction.
- `q` out N: binary quotient, registered.
- `r` out N: binary remainder, registered.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts result.

## Operation
- SD2 digit decode:
  - 2'b00 = 0.
  - 2'b01 and 2'b10 = +1.
  - 2'b11 = −1.
- Split each SD2 vector into P (bit i set where digit i = +1) and M (bit i set where digit i = −1). Binary value = P − M, computed mod 2^N.
- Correction rule:
  - `seladj`=1: Q = Qb, R = Rb.
  - `seladj`=0, `padj`=1: Q = Qb + 1, R = Rb − x.
  - `seladj`=0, `padj`=0: Q = Qb − 1, R = Rb + x.
- All arithmetic is N-bit and wraps modulo 2^N. No overflow flag.
- FSM states: IDLE, CONVQ, CONVR, CORRQ, CORRR, DONE.
  - IDLE: `in_ready`=1. `in_valid`=1 latches q_sd, r_sd, x, padj and seladj into internal registers, then → CONVQ.
  - CONVQ: q ← P_q − M_q, → CONVR.
  - CONVR: r ← P_r − M_r. Go → CORRQ if latched seladj=0, else → DONE.
  - CORRQ: q ← q ± 1 per latched padj, → CORRR.
  - CORRR: r ← r ∓ x per latched padj, → DONE.
  - DONE: `out_valid`=1. q and r are held stable. `out_ready`=1 → IDLE.
- Inputs are sampled only on the accept edge. Later input changes have no effect on the operation in progress.

## Timing
- Reset values:
  - State IDLE.
  - `q`=0, `r`=0, `out_valid`=0, `in_ready`=1.
  - Internal latches cleared.
- Latency, counted from the accept edge to the first cycle with `out_valid`=1:
  - 3 cycles when seladj=1.
  - 5 cycles when seladj=0.
- Throughput: one bundle per (latency + 1) cycles at best. No overlap.
- DONE with `out_ready`=1: transfer completes on that edge. The next cycle is IDLE with `out_valid`=0 and `in_ready`=1.
- `in_valid` during DONE is ignored, because `in_ready`=0. The same applies in every state other than IDLE. There is no same-cycle accept-on-release.
- `out_ready` outside DONE has no effect.
- `rst` in any state, including mid-conversion or DONE: the next cycle shows reset values. The partial result is discarded.
- `out_valid` and `in_ready` are decoded from registered state. No combinational path from `out_ready` or `in_valid` to any output.

## Structure
- Shared package `intdiv_pkg` holds:
  - The SD2 encodings NEG1 = 2'b11, ZERO = 2'b00, POS1_1 = 2'b01, POS1_2 = 2'b10.
  - ON/OFF and NEGATIVE/POSITIVE constants.
  - The FSM state enum.
  - An SD2-to-(P,M) split function, reused by other divider stages.
- Sub-module `intdiv_addsub`: combinational N-bit a ± b, with a `sub` control, wrap-around result and no carry out.
  - Single instance.
  - Operand muxing is selected by FSM state: P/M, q/1, r/x.

## Test plan
All scenarios use N=8.
1. q_sd digit3=01, digit0=11, others 00 (P=0x08, M=0x01); r_sd digit1=10; seladj=1. Required: q=0x07, r=0x02; out_valid rises 3 cycles after accept.
2. Same operands, x=0x05, seladj=0, padj=0. Required: q=0x06, r=0x07; out_valid 5 cycles after accept.
3. Same operands, x=0x05, seladj=0, padj=1. Required: q=0x08, r=0xFD.
4. Wrap case: q_sd digit0=01, digit1=11 (Qb=0xFF), seladj=0, padj=1, x=0x01, r_sd all 00. Required: q=0x00, r=0xFF.
5. Backpressure: out_ready held 0 for 4 cycles in DONE while in_valid=1 with new data. Required:
   - q, r and out_valid stay stable; in_ready=0.
   - After out_ready=1: IDLE next cycle with in_ready=1.
   - The new bundle is accepted only then.
6. rst pulsed during CORRQ. Required: next cycle q=0, r=0, out_valid=0, in_ready=1. A following bundle then converts correctly.
